// File: rtl/alu_serial_sequencer_if.sv
// Request/response bundle for the bit-serial ALU sequencer: operation request
// in, busy/done/result back.
interface alu_serial_sequencer_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op_a, op_b, op_sel,
    input  busy, done, result
  );

  modport slave (
    input  start, op_a, op_b, op_sel,
    output busy, done, result
  );
endinterface

// File: rtl/alu_serial_sequencer.sv
// Bit-serial controller around a 1-bit combinational ALU: streams operands
// LSB-first, gathers ALU_Out into a WIDTH-bit result, pulses done.
module alu_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_serial_sequencer_if.slave   req,
  output logic                    alu_a,
  output logic                    alu_b,
  output logic [2:0]              alu_sel,
  input  logic                    alu_out
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [2:0]       sel_q,    sel_d;
  logic [WIDTH-2:0] acc_q,    acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] shifted;

  // The final ALU bit joins the WIDTH-1 bits already gathered; the same word
  // seeds the next accumulator value, so the result needs no extra shift.
  assign shifted = {alu_out, acc_q};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can hold
    // a previous value and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    acc_d    = acc_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (req.start) begin
          a_d     = req.op_a;
          b_d     = req.op_b;
          sel_d   = req.op_sel;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = shifted[WIDTH-1:1];
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = shifted;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the operand and accumulator registers are cleared too, so an
      // aborted operation leaves no stale bits behind.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // ALU drive is forced to zero outside SHIFT so the ALU sees a quiet input.
  assign alu_a   = (state_q == S_SHIFT) ? a_q[0] : 1'b0;
  assign alu_b   = (state_q == S_SHIFT) ? b_q[0] : 1'b0;
  assign alu_sel = (state_q == S_SHIFT) ? sel_q  : 3'b000;

  assign req.busy   = (state_q == S_SHIFT);
  assign req.done   = (state_q == S_DONE);
  assign req.result = result_q;

endmodule
